// File: rtl/flag_branch_unit_pkg.sv
// Shared types for the flag/branch unit: branch kinds, condition codes and
// the bit positions of N, Z, C and V inside the 4-bit flag word.
package flag_branch_unit_pkg;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_COND = 2'b01,
    BR_CBZ  = 2'b10,
    BR_CBNZ = 2'b11
  } br_type_e;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_HS = 4'b0010,
    COND_LO = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/flag_branch_unit_cond_eval.sv
// Purely combinational evaluation of a B.cond condition code against a
// {N,Z,C,V} flag word.
module cond_eval
  import flag_branch_unit_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       result
);

  logic n, z, c, v;

  always_comb begin
    n = flags[FLAG_N];
    z = flags[FLAG_Z];
    c = flags[FLAG_C];
    v = flags[FLAG_V];
    result = 1'b0;
    case (cond_e'(cond))
      COND_EQ: result = z;
      COND_NE: result = !z;
      COND_HS: result = c;
      COND_LO: result = !c;
      COND_MI: result = n;
      COND_PL: result = !n;
      COND_VS: result = v;
      COND_VC: result = !v;
      COND_HI: result = c & !z;
      COND_LS: result = !c | z;
      COND_GE: result = (n == v);
      COND_LT: result = (n != v);
      COND_GT: result = !z & (n == v);
      COND_LE: result = z | (n != v);
      // NV behaves as always-taken, same as AL.
      COND_AL: result = 1'b1;
      COND_NV: result = 1'b1;
      default: result = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_branch_unit.sv
// Flag register with EX->ID forwarding, branch decision for the ID-stage
// instruction, one-cycle wrong-path flush and a saturating taken counter.
module flag_branch_unit
  import flag_branch_unit_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_valid,
  input  logic             set_flags,
  input  logic             alu_neg,
  input  logic             alu_zero,
  input  logic             alu_cout,
  input  logic             alu_ovf,
  input  logic             stall,
  input  logic [1:0]       br_type,
  input  logic [3:0]       cond,
  input  logic             op_zero,
  output logic             take_branch,
  output logic             flush,
  output logic [3:0]       flags_q,
  output logic [CNT_W-1:0] taken_cnt
);

  logic             flag_wr;
  logic [3:0]       alu_flags;
  logic [3:0]       eff_flags;
  logic             cond_res;
  logic [3:0]       flags_d;
  logic             flush_q, flush_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign alu_flags = {alu_neg, alu_zero, alu_cout, alu_ovf};

  cond_eval u_cond_eval (
    .cond   (cond),
    .flags  (eff_flags),
    .result (cond_res)
  );

  always_comb begin
    flag_wr   = ex_valid & set_flags;
    // A flag-setting instruction in EX is seen by a B.cond in ID the same cycle.
    eff_flags = flag_wr ? alu_flags : flags_q;
    take_branch = 1'b0;
    case (br_type_e'(br_type))
      BR_NONE: take_branch = 1'b0;
      BR_COND: take_branch = cond_res;
      BR_CBZ:  take_branch = op_zero;
      BR_CBNZ: take_branch = !op_zero;
      default: take_branch = 1'b0;
    endcase
  end

  always_comb begin
    flags_d = flags_q;
    flush_d = flush_q;
    cnt_d   = cnt_q;
    if (!stall) begin
      if (flag_wr) flags_d = alu_flags;
      flush_d = take_branch;
      if (take_branch && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= 4'b0000;
      flush_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      flags_q <= flags_d;
      flush_q <= flush_d;
      cnt_q   <= cnt_d;
    end
  end

  assign flush     = flush_q;
  assign taken_cnt = cnt_q;

endmodule

// File: tb/tb_flag_branch_unit.sv
// Self-checking bench for flag_branch_unit: directed vector table, hand
// sequences for stall/reset/saturation, then a short random phase.
module tb_flag_branch_unit;

  localparam int CNT_W = 4;
  localparam int W     = 4 + 1 + CNT_W;

  logic             clk;
  logic             reset;
  logic             ex_valid, set_flags;
  logic             alu_neg, alu_zero, alu_cout, alu_ovf;
  logic             stall;
  logic [1:0]       br_type;
  logic [3:0]       cond;
  logic             op_zero;
  logic             take_branch;
  logic             flush;
  logic [3:0]       flags_q;
  logic [CNT_W-1:0] taken_cnt;

  flag_branch_unit #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .ex_valid    (ex_valid),
    .set_flags   (set_flags),
    .alu_neg     (alu_neg),
    .alu_zero    (alu_zero),
    .alu_cout    (alu_cout),
    .alu_ovf     (alu_ovf),
    .stall       (stall),
    .br_type     (br_type),
    .cond        (cond),
    .op_zero     (op_zero),
    .take_branch (take_branch),
    .flush       (flush),
    .flags_q     (flags_q),
    .taken_cnt   (taken_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ev;
    logic       sf;
    logic [3:0] alu;
    logic       st;
    logic [1:0] bt;
    logic [3:0] cd;
    logic       oz;
    logic       tk;
  } vec_t;

  vec_t vecs[20];

  logic [W-1:0]     exp_q[$];
  logic [3:0]       m_flags;
  logic             m_flush;
  logic [CNT_W-1:0] m_cnt;
  int               total;
  int               bad;

  // Independent reference for the branch decision used by the random phase.
  function automatic logic ref_take(logic ev, logic sf, logic [3:0] alu, logic [3:0] fq,
                                    logic [1:0] bt, logic [3:0] cd, logic oz);
    logic [3:0] f;
    logic n, z, c, v, r;
    f = (ev && sf) ? alu : fq;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (cd)
      4'd0:  r = z;
      4'd1:  r = ~z;
      4'd2:  r = c;
      4'd3:  r = ~c;
      4'd4:  r = n;
      4'd5:  r = ~n;
      4'd6:  r = v;
      4'd7:  r = ~v;
      4'd8:  r = c && !z;
      4'd9:  r = !c || z;
      4'd10: r = (n ~^ v);
      4'd11: r = (n ^ v);
      4'd12: r = !z && (n ~^ v);
      4'd13: r = z || (n ^ v);
      default: r = 1'b1;
    endcase
    if (bt == 2'b00) return 1'b0;
    if (bt == 2'b10) return oz;
    if (bt == 2'b11) return ~oz;
    return r;
  endfunction

  function automatic vec_t mk(logic ev, logic sf, logic [3:0] alu, logic st,
                              logic [1:0] bt, logic [3:0] cd, logic oz, logic tk);
    vec_t x;
    x.ev = ev; x.sf = sf; x.alu = alu; x.st = st;
    x.bt = bt; x.cd = cd; x.oz = oz; x.tk = tk;
    return x;
  endfunction

  task automatic check_state(string name);
    logic [W-1:0] exp;
    logic [W-1:0] act;
    if (exp_q.size() == 0) begin
      total++; bad++;
      $display("FAIL %s: scoreboard empty", name);
      return;
    end
    exp = exp_q.pop_front();
    act = {flags_q, flush, taken_cnt};
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: flags/flush/cnt got %b/%b/%0d want %b/%b/%0d", name,
               act[W-1 -: 4], act[CNT_W], act[CNT_W-1:0],
               exp[W-1 -: 4], exp[CNT_W], exp[CNT_W-1:0]);
    end
  endtask

  // Driver: called at posedge+1; checks take_branch combinationally, pushes
  // the expected post-edge state, crosses the edge and compares.
  task automatic step(string name, logic rst, vec_t x);
    reset = rst;
    ex_valid = x.ev; set_flags = x.sf;
    {alu_neg, alu_zero, alu_cout, alu_ovf} = x.alu;
    stall = x.st; br_type = x.bt; cond = x.cd; op_zero = x.oz;
    #1;
    total++;
    if (take_branch !== x.tk) begin
      bad++;
      $display("FAIL %s take_branch: got %b want %b", name, take_branch, x.tk);
    end
    if (rst) begin
      m_flags = 4'b0000; m_flush = 1'b0; m_cnt = '0;
    end else if (!x.st) begin
      if (x.ev && x.sf) m_flags = x.alu;
      m_flush = x.tk;
      if (x.tk && m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
    end
    exp_q.push_back({m_flags, m_flush, m_cnt});
    @(posedge clk);
    #1;
    check_state(name);
  endtask

  initial begin
    total = 0; bad = 0;
    m_flags = 4'b0000; m_flush = 1'b0; m_cnt = '0;
    reset = 1'b1; ex_valid = 0; set_flags = 0;
    {alu_neg, alu_zero, alu_cout, alu_ovf} = 4'b0000;
    stall = 0; br_type = 2'b00; cond = 4'b0000; op_zero = 0;

    //          ev  sf  alu      st  bt     cd       oz  tk
    vecs[0]  = mk(1, 1, 4'b0100, 0, 2'b00, 4'b0000, 0, 0); // SUBS Z=1
    vecs[1]  = mk(0, 0, 4'b0000, 0, 2'b01, 4'b0000, 0, 1); // EQ taken
    vecs[2]  = mk(0, 0, 4'b0000, 0, 2'b00, 4'b0000, 0, 0);
    vecs[3]  = mk(1, 1, 4'b0000, 0, 2'b00, 4'b0000, 0, 0); // clear flags
    vecs[4]  = mk(1, 1, 4'b1000, 0, 2'b01, 4'b1011, 0, 1); // fwd LT
    vecs[5]  = mk(1, 1, 4'b1000, 0, 2'b01, 4'b1010, 0, 0); // fwd GE
    vecs[6]  = mk(1, 1, 4'b0000, 0, 2'b00, 4'b0000, 0, 0);
    vecs[7]  = mk(0, 0, 4'b0000, 0, 2'b10, 4'b0000, 1, 1); // CBZ
    vecs[8]  = mk(0, 0, 4'b0000, 0, 2'b11, 4'b0000, 1, 0); // CBNZ zero
    vecs[9]  = mk(0, 0, 4'b0000, 0, 2'b11, 4'b0000, 0, 1); // CBNZ nonzero
    vecs[10] = mk(1, 0, 4'b1111, 0, 2'b01, 4'b0000, 0, 0); // no set_flags
    vecs[11] = mk(0, 1, 4'b0100, 0, 2'b01, 4'b0000, 0, 0); // not valid
    vecs[12] = mk(1, 1, 4'b0010, 0, 2'b01, 4'b1000, 0, 1); // HI
    vecs[13] = mk(0, 0, 4'b0000, 0, 2'b01, 4'b1001, 0, 0); // LS
    vecs[14] = mk(0, 0, 4'b0000, 0, 2'b01, 4'b0010, 0, 1); // HS
    vecs[15] = mk(0, 0, 4'b0000, 0, 2'b01, 4'b1111, 0, 1); // NV, back-to-back
    vecs[16] = mk(1, 1, 4'b0101, 0, 2'b01, 4'b1100, 0, 0); // GT
    vecs[17] = mk(0, 0, 4'b0000, 0, 2'b01, 4'b1101, 0, 1); // LE
    vecs[18] = mk(0, 0, 4'b0000, 0, 2'b01, 4'b0110, 0, 1); // VS
    vecs[19] = mk(0, 0, 4'b0000, 0, 2'b01, 4'b0100, 0, 0); // MI

    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back({4'b0000, 1'b0, {CNT_W{1'b0}}});
    check_state("reset_state");

    for (int i = 0; i < 20; i++) step($sformatf("vec%0d", i), 1'b0, vecs[i]);

    // stall holds everything, release applies the pending update
    step("pre_stall", 1'b0, mk(0, 0, 4'b0000, 0, 2'b00, 4'b0000, 0, 0));
    for (int i = 0; i < 3; i++)
      step($sformatf("stall%0d", i), 1'b0, mk(1, 1, 4'b1001, 1, 2'b01, 4'b1110, 0, 1));
    step("stall_release", 1'b0, mk(1, 1, 4'b1001, 0, 2'b01, 4'b1110, 0, 1));

    // reset during a taken branch with a flag write, then no leftover flush
    step("reset_mid", 1'b1, mk(1, 1, 4'b1111, 0, 2'b01, 4'b1110, 0, 1));
    step("after_reset", 1'b0, mk(0, 0, 4'b0000, 0, 2'b00, 4'b0000, 0, 0));

    // 20 taken branches saturate the 4-bit counter at 15
    for (int i = 0; i < 20; i++)
      step($sformatf("sat%0d", i), 1'b0, mk(0, 0, 4'b0000, 0, 2'b01, 4'b1110, 0, 1));
    total++;
    if (taken_cnt !== 4'd15) begin
      bad++;
      $display("FAIL saturate: taken_cnt got %0d want 15", taken_cnt);
    end

    step("sat_clear", 1'b1, mk(0, 0, 4'b0000, 0, 2'b00, 4'b0000, 0, 0));
    for (int i = 0; i < 40; i++) begin
      vec_t r;
      r.ev  = 1'($urandom_range(0, 1));
      r.sf  = 1'($urandom_range(0, 1));
      r.alu = 4'($urandom_range(0, 15));
      r.st  = ($urandom_range(0, 3) == 0);
      r.bt  = 2'($urandom_range(0, 3));
      r.cd  = 4'($urandom_range(0, 15));
      r.oz  = 1'($urandom_range(0, 1));
      r.tk  = ref_take(r.ev, r.sf, r.alu, m_flags, r.bt, r.cd, r.oz);
      step($sformatf("rand%0d", i), 1'b0, r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/flag_branch_unit.md
FLAG_BRANCH_UNIT -- requirements
Module: flag_branch_unit

Interface
REQ-001 Parameter: CNT_W, 16, width of the taken-branch counter.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: ex_valid  input  1  EX-stage instruction is valid.
REQ-005 Port: set_flags  input  1  EX-stage instruction writes flags (ADDS/SUBS).
REQ-006 Port: alu_neg, alu_zero, alu_cout, alu_ovf  input  1 each  ALU flag results of the EX-stage instruction.
REQ-007 Port: stall  input  1  hold all state; no flag write, no flush launch, no count.
REQ-008 Port: br_type  input  2  ID-stage branch kind: 00 none, 01 B.cond, 10 CBZ, 11 CBNZ.
REQ-009 Port: cond  input  4  B.cond condition code.
REQ-010 Port: op_zero  input  1  zero-detect of the CBZ/CBNZ register operand, already computed.
REQ-011 Port: take_branch  output  1  combinational branch decision for the ID-stage instruction.
REQ-012 Port: flush  output  1  registered; squash the wrong-path fetch one cycle after a taken branch.
REQ-013 Port: flags_q  output  4  architectural {N,Z,C,V} register.
REQ-014 Port: taken_cnt  output  CNT_W  saturating count of taken branches.

Function
REQ-015 flags_q SHALL load {alu_neg,alu_zero,alu_cout,alu_ovf} on the edge where ex_valid & set_flags & !stall; otherwise it holds.
REQ-016 Effective flags SHALL be the ALU flags when ex_valid & set_flags, else flags_q (EX->ID forward; zero-cycle latency).
REQ-017 take_branch SHALL be 0 when br_type=00.
REQ-018 br_type=10 SHALL yield take_branch=op_zero; br_type=11 SHALL yield !op_zero; flags are ignored for both.
REQ-019 br_type=01 SHALL evaluate cond on effective flags: 0000 EQ Z; 0001 NE !Z; 0010 HS C; 0011 LO !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V; 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 NV 1.
REQ-020 take_branch SHALL be evaluated even while stall=1; only state updates are held.
REQ-021 flush SHALL equal take_branch & !stall registered; it is high for exactly one cycle per taken, non-stalled branch.
REQ-022 While stall=1, flush SHALL hold its previous value.
REQ-023 Taken branches on consecutive non-stalled cycles SHALL keep flush high on each following cycle.
REQ-024 taken_cnt SHALL increment by 1 on each edge where take_branch & !stall, and SHALL saturate at 2^CNT_W-1 with no wrap.
REQ-025 A flag write and a B.cond in the same cycle SHALL use the forwarded (new) flags; flags_q updates at that edge.

Reset
REQ-026 On an edge with reset=1: flags_q=4'b0000, flush=0, taken_cnt=0; reset overrides stall and any concurrent flag write.
REQ-027 take_branch SHALL remain purely combinational during reset; a flush launched by the reset cycle is suppressed.
REQ-028 Reset asserted mid-sequence SHALL leave no pending flush in the cycle after reset deasserts.

Structure
REQ-029 A shared package SHALL hold the br_type enum (BR_NONE, BR_COND, BR_CBZ, BR_CBNZ), the 4-bit cond enum (EQ..NV), and flag bit indices N=3, Z=2, C=1, V=0.
REQ-030 One sub-module, cond_eval, SHALL be purely combinational, mapping (cond, flags[3:0]) to a 1-bit result; all state lives in flag_branch_unit.

Verification
REQ-031 Reset, then SUBS with alu flags 0100 (Z=1), set_flags=1, next cycle B.cond EQ -> take_branch=1 in that cycle, flush=1 the next cycle, flags_q=0100, taken_cnt=1.
REQ-032 Same-cycle forward: flags_q=0000, EX sets N=1,V=0 while ID has B.cond LT -> take_branch=1; with GE -> 0.
REQ-033 CBZ with op_zero=1 and flags_q=0000 -> take_branch=1; CBNZ with op_zero=1 -> 0; flags_q unchanged.
REQ-034 stall=1 for 3 cycles with a taken branch and set_flags=1 -> flags_q, flush, taken_cnt unchanged; release -> all three update on the next edge.
REQ-035 CNT_W=4, drive 20 taken non-stalled branches -> taken_cnt saturates at 15.
REQ-036 Assert reset during a taken branch with set_flags=1 and flags 1111 -> next cycle flags_q=0000, flush=0, taken_cnt=0.
